// File: rtl/rec2pol_sched.sv
`timescale 1ns/1ps
// rec2pol_sched: round-robin arbiter that time-shares one rec2pol CORDIC core
// among NREQ phase channels and returns each captured angle to its requester.
module rec2pol_sched #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [13*NREQ-1:0]   x_in,
    input  logic [13*NREQ-1:0]   y_in,
    output logic [NREQ-1:0]      done,
    output logic [18:0]          angle_out,
    output logic [2:0]           done_id,
    output logic                 busy,
    output logic                 r2p_start,
    output logic [12:0]          r2p_x,
    output logic [12:0]          r2p_y,
    input  logic [18:0]          r2p_angle
);

    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [2:0]       ptr_r;
    logic [2:0]       gnt_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       pick_s;
    logic [12:0]      pick_x_s;
    logic [12:0]      pick_y_s;

    // Returns {valid, index} of the first set request at or above p, wrapping.
    // Scanning from the far end downward lets the nearest hit overwrite the rest.
    function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] p);
        logic [3:0] res;
        int         idx;
        res = 4'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (r[idx]) begin
                res = {1'b1, 3'(idx)};
            end
        end
        return res;
    endfunction

    // Arbitration result and the selected channel's operands.
    always_comb begin
        pick_s   = rr_pick(req, ptr_r);
        pick_x_s = x_in[int'(pick_s[2:0]) * 13 +: 13];
        pick_y_s = y_in[int'(pick_s[2:0]) * 13 +: 13];
    end

    // Next-state logic for the grant / start / wait / done sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_s[3]) begin
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: state_nx_s = WAIT;
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, datapath latches and registered Moore outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            ptr_r     <= 3'd0;
            gnt_r     <= 3'd0;
            cnt_r     <= {CNT_W{1'b0}};
            done      <= {NREQ{1'b0}};
            done_id   <= 3'd0;
            angle_out <= 19'd0;
            busy      <= 1'b0;
            r2p_start <= 1'b0;
            r2p_x     <= 13'd0;
            r2p_y     <= 13'd0;
        end else begin
            state_r   <= state_nx_s;
            busy      <= (state_nx_s != IDLE);
            r2p_start <= (state_nx_s == START);
            done      <= {NREQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (pick_s[3]) begin
                        gnt_r <= pick_s[2:0];
                        r2p_x <= pick_x_s;
                        r2p_y <= pick_y_s;
                    end
                end
                START: cnt_r <= CNT_W'(LATENCY - 1);
                WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        angle_out <= r2p_angle;
                        done      <= ONE_HOT0 << gnt_r;
                        done_id   <= gnt_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                // Advance past the channel just served so a busy channel cannot starve others.
                DONE: ptr_r <= (gnt_r == 3'(NREQ - 1)) ? 3'd0 : gnt_r + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rec2pol_sched.sv
`timescale 1ns/1ps
// tb_rec2pol_sched: randomized and directed checks of the scheduler against a
// conversion-level reference model; a behavioural rec2pol stand-in supplies angles.
module tb_rec2pol_sched;

    localparam int NREQ    = 4;
    localparam int LATENCY = 16;
    localparam int DONE_T  = LATENCY + 2;

    logic                clock;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [13*NREQ-1:0]  x_in;
    logic [13*NREQ-1:0]  y_in;
    logic [NREQ-1:0]     done;
    logic [18:0]         angle_out;
    logic [2:0]          done_id;
    logic                busy;
    logic                r2p_start;
    logic [12:0]         r2p_x;
    logic [12:0]         r2p_y;
    logic [18:0]         r2p_angle;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_t counts cycles into a conversion (0 = free, 1 = start cycle, DONE_T = done cycle).
    int m_t, m_ptr, m_gnt, m_x, m_y, m_angle, m_done_id;

    rec2pol_sched #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .done      (done),
        .angle_out (angle_out),
        .done_id   (done_id),
        .busy      (busy),
        .r2p_start (r2p_start),
        .r2p_x     (r2p_x),
        .r2p_y     (r2p_y),
        .r2p_angle (r2p_angle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sx13(input logic [12:0] v);
        return int'($signed(v));
    endfunction

    function automatic int ref_angle(input int x, input int y);
        real a;
        if (x == 0 && y == 0) return 0;
        a = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979323846 * 1024.0;
        return int'(a);
    endfunction

    function automatic int rnd13();
        return int'($urandom_range(8190)) - 4095;
    endfunction

    task automatic set_xy(input int ch, input int x, input int y);
        x_in[13*ch +: 13] = 13'(x);
        y_in[13*ch +: 13] = 13'(y);
    endtask

    task automatic model_reset();
        m_t = 0; m_ptr = 0; m_gnt = 0; m_x = 0; m_y = 0; m_angle = 0; m_done_id = 0;
    endtask

    task automatic model_edge();
        int  c;
        bit  found;
        found = 1'b0;
        if (reset) begin
            model_reset();
        end else if (m_t == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!found && req[c]) begin
                    found = 1'b1;
                    m_gnt = c;
                    m_x   = sx13(x_in[13*c +: 13]);
                    m_y   = sx13(y_in[13*c +: 13]);
                end
            end
            if (found) m_t = 1;
        end else if (m_t == DONE_T) begin
            m_t   = 0;
            m_ptr = (m_gnt + 1) % NREQ;
        end else begin
            m_t++;
            if (m_t == DONE_T) begin
                m_angle   = ref_angle(m_x, m_y);
                m_done_id = m_gnt;
            end
        end
    endtask

    // One clock: advance the model on the edge, then compare every output 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
        model_edge();
        check_eq("busy",      32'(busy),      32'(m_t != 0));
        check_eq("r2p_start", 32'(r2p_start), 32'(m_t == 1));
        check_eq("done",      32'(done),      (m_t == DONE_T) ? (1 << m_gnt) : 0);
        check_eq("done_id",   32'(done_id),   m_done_id);
        check_eq("angle_out", 32'($signed(angle_out)), m_angle);
        check_eq("r2p_x",     32'($signed(r2p_x)),     m_x);
        check_eq("r2p_y",     32'($signed(r2p_y)),     m_y);
    endtask

    // Behavioural rec2pol: angle valid only in the single cycle the scheduler should capture it.
    initial begin
        int cx, cy, ang;
        bit aborted;
        r2p_angle = 19'd0;
        forever begin
            @(posedge clock);
            #1;
            if (r2p_start === 1'b1 && reset === 1'b0) begin
                cx = sx13(r2p_x);
                cy = sx13(r2p_y);
                ang = ref_angle(cx, cy);
                aborted = 1'b0;
                r2p_angle = 19'(ang) ^ 19'h2AAAA;
                for (int k = 0; k < LATENCY && !aborted; k++) begin
                    @(posedge clock);
                    #1;
                    if (reset) aborted = 1'b1;
                end
                if (!aborted) begin
                    r2p_angle = 19'(ang);
                    @(posedge clock);
                    #1;
                end
                r2p_angle = 19'(ang) ^ 19'h2AAAA;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, starts, first_start, idle_gaps, spurious;
        bit started, raise0;
        int ids[$];
        int angs[$];
        int exp_ang[4];
        int exp_ids[4];

        model_reset();
        req = '0; x_in = '0; y_in = '0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();

        // Idle with no requests
        repeat (50) begin
            tick();
            check_eq("idle_busy",  32'(busy),      0);
            check_eq("idle_start", 32'(r2p_start), 0);
            check_eq("idle_done",  32'(done),      0);
        end

        // Single request on ch2
        set_xy(2, 4095, 4095);
        req = 4'b0100;
        tick();
        cyc = 1; starts = 0; first_start = 0;
        if (r2p_start) begin starts++; first_start = cyc; end
        while (done == '0 && cyc < 60) begin
            tick();
            cyc++;
            if (r2p_start) starts++;
        end
        check_eq("t1_done_cycle",  cyc, DONE_T);
        check_eq("t1_start_count", starts, 1);
        check_eq("t1_start_cycle", first_start, 1);
        check_eq("t1_done_vec",    32'(done), 4);
        check_eq("t1_done_id",     32'(done_id), 2);
        check_eq("t1_angle",       32'($signed(angle_out)), 46080);
        req = '0;
        repeat (3) tick();

        // Four simultaneous requests after reset
        reset = 1'b1; tick(); reset = 1'b0;
        set_xy(0, 4095, 0); set_xy(1, 0, 4095); set_xy(2, -4095, 0); set_xy(3, 0, -4095);
        exp_ang[0] = 0; exp_ang[1] = 92160; exp_ang[2] = 184320; exp_ang[3] = -92160;
        req = 4'b1111;
        started = 1'b0; idle_gaps = 0;
        for (int c = 0; c < 4 * (LATENCY + 3) + 10 && ids.size() < 4; c++) begin
            tick();
            if (busy) started = 1'b1;
            else if (started) idle_gaps++;
            if (done != '0) begin
                ids.push_back(int'(done_id));
                angs.push_back(int'($signed(angle_out)));
                req = req & ~done;
            end
        end
        check_eq("t2_count", ids.size(), 4);
        check_eq("t2_idle_gaps", idle_gaps, 3);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_order", (ids.size() > i) ? ids[i] : -1, i);
            check_eq("t2_angle", (angs.size() > i) ? angs[i] : -1, exp_ang[i]);
        end
        req = '0;
        repeat (3) tick();

        // Fairness: ch0 re-requests after each done, ch1 held high
        ids.delete();
        set_xy(0, 1000, 2000); set_xy(1, -3000, 500);
        req = 4'b0011; raise0 = 1'b0;
        for (int c = 0; c < 4 * (LATENCY + 3) + 20 && ids.size() < 4; c++) begin
            tick();
            if (raise0) begin req[0] = 1'b1; raise0 = 1'b0; end
            if (done != '0) begin
                ids.push_back(int'(done_id));
                if (done[0]) begin req[0] = 1'b0; raise0 = 1'b1; end
            end
        end
        req = '0;
        exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 0; exp_ids[3] = 1;
        check_eq("t3_count", ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_grant", (ids.size() > i) ? ids[i] : -1, exp_ids[i]);
        end
        repeat (LATENCY + 4) tick();

        // Request dropped mid-WAIT with operands changed after grant
        set_xy(1, -4095, 4095);
        req = 4'b0010;
        tick();
        repeat (5) tick();
        req = '0;
        set_xy(1, 100, -3000);
        for (int c = 0; c < LATENCY + 10 && done == '0; c++) begin
            tick();
            if (done == '0) begin
                check_eq("t4_hold_x", 32'($signed(r2p_x)), -4095);
                check_eq("t4_hold_y", 32'($signed(r2p_y)), 4095);
            end
        end
        check_eq("t4_done_vec", 32'(done), 2);
        check_eq("t4_angle",    32'($signed(angle_out)), 138240);
        repeat (3) tick();

        // Reset in the middle of WAIT
        set_xy(0, 4095, 0);
        req = 4'b0001;
        tick();
        repeat (6) tick();
        #3 reset = 1'b1;
        #1;
        check_eq("t5_rst_done",    32'(done), 0);
        check_eq("t5_rst_done_id", 32'(done_id), 0);
        check_eq("t5_rst_angle",   32'(angle_out), 0);
        check_eq("t5_rst_busy",    32'(busy), 0);
        check_eq("t5_rst_start",   32'(r2p_start), 0);
        check_eq("t5_rst_x",       32'(r2p_x), 0);
        check_eq("t5_rst_y",       32'(r2p_y), 0);
        req = '0;
        tick(); tick();
        reset = 1'b0;
        spurious = 0;
        repeat (LATENCY + 5) begin
            tick();
            if (done != '0) spurious++;
        end
        check_eq("t5_no_done", spurious, 0);
        ids.delete();
        set_xy(1, 2000, -2000); set_xy(3, -1500, -2500);
        req = 4'b1010;
        for (int c = 0; c < 2 * (LATENCY + 3) + 10 && ids.size() < 2; c++) begin
            tick();
            if (done != '0) begin
                ids.push_back(int'(done_id));
                req = req & ~done;
            end
        end
        check_eq("t5_count",  ids.size(), 2);
        check_eq("t5_first",  (ids.size() > 0) ? ids[0] : -1, 1);
        check_eq("t5_second", (ids.size() > 1) ? ids[1] : -1, 3);
        req = '0;
        repeat (3) tick();

        // Randomized requesters against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(7) == 0) begin
                        set_xy(i, rnd13(), rnd13());
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(15) == 0) begin
                    set_xy(i, rnd13(), rnd13());
                end else if ($urandom_range(63) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        repeat (LATENCY + 5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rec2pol_sched.md
# rec2pol_sched

Round-robin scheduler sharing one `rec2pol` CORDIC core among `NREQ` requesters (one per hydrophone-pair phase channel). Grants one request at a time, latches its X/Y, pulses the core's `start`, waits the fixed core latency, captures `angle`, and returns it to the granted requester with a one-cycle `done` strobe. Sits between the per-channel phase-difference front ends and the single `rec2pol` instance.

## Interface

Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `LATENCY`, 16: cycles from the `r2p_start` cycle to a valid `r2p_angle`; must be ≥ the `rec2pol` latency.

Ports:
- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `req`  in  NREQ: per-requester request level, held high until its `done` bit.
- `x_in`  in  13*NREQ: packed two's-complement X, requester i at bits [13*i+12:13*i].
- `y_in`  in  13*NREQ: packed two's-complement Y, same packing.
- `done`  out  NREQ: one-hot, one-cycle completion strobe.
- `angle_out`  out  19: signed angle, degrees × 1024, valid while `done` != 0, held until next capture.
- `done_id`  out  3: index of the requester that `done` refers to.
- `busy`  out  1: high whenever the core is allocated.
- `r2p_start`  out  1: to `rec2pol.start`.
- `r2p_x`, `r2p_y`  out  13 each: to `rec2pol.x` / `.y`.
- `r2p_angle`  in  19: from `rec2pol.angle`.

## Operation

- FSM states: IDLE, START, WAIT, DONE.
- IDLE: if any `req` bit high, select the first set bit searching upward from pointer `ptr`, wrapping modulo NREQ. Latch that channel's X/Y into `r2p_x`/`r2p_y` and its index into `gnt`. Go to START. Otherwise remain in IDLE.
- START: `r2p_start`=1 for exactly this cycle. Load wait counter with `LATENCY`-1. Go to WAIT.
- WAIT: decrement the counter. When the counter is 0, register `r2p_angle` into `angle_out` and go to DONE.
- DONE: `done[gnt]`=1 and `done_id`=`gnt`. Set `ptr`=(`gnt`+1) mod NREQ. Go to IDLE.
- `r2p_x`/`r2p_y` are held stable from grant through DONE. Requester inputs may change after grant without effect.
- A requester deasserting `req` after grant does not abort the conversion; `done` still pulses.
- Requesters must drop `req` in the cycle they see `done`. A `req` still high in the following IDLE cycle is a new request.
- `req` changes during START/WAIT/DONE are ignored until IDLE.
- `busy`=1 in START, WAIT and DONE.
- All outputs are registered (Moore).
- No arithmetic on angle: 19-bit pass-through. X/Y are 13-bit pass-through; the range ±4095 is the caller's responsibility.
- Reset (async, any state): state=IDLE, `ptr`=0, `gnt`=0, counter=0, `done`=0, `done_id`=0, `angle_out`=0, `busy`=0, `r2p_start`=0, `r2p_x`=0, `r2p_y`=0.
- An in-flight conversion is discarded on reset; no `done` is issued for it. `rec2pol` shares the same reset.

## Timing

- Request sampled high at IDLE edge E0. `r2p_start` is high in the cycle after E0 (START).
- WAIT lasts `LATENCY` cycles. `done` is high in cycle E0+`LATENCY`+2.
- Per-conversion occupancy: `LATENCY`+3 cycles including the IDLE grant cycle.
- Back-to-back throughput: a new grant occurs in the IDLE cycle right after DONE.
- Simultaneous requests: the lowest index at or above `ptr` wins. A continuously requesting channel cannot starve others; the maximum wait is NREQ conversions.
- `angle_out` changes only on the WAIT→DONE edge or on reset.

## Test plan

- Single request: ch2, x=4095, y=4095, `LATENCY`=16. Required: `r2p_start` pulses once, one cycle after the grant; `done`=4'b0100 and `done_id`=2 exactly 18 cycles after the sampling edge; `angle_out`≈46080 (45°), within ±0.1°.
- All four requests asserted together, with (4095,0), (0,4095), (−4095,0), (0,−4095), each dropped on its own `done`. Required: service order 0,1,2,3; angles ≈0, 92160, 184320, −92160; `busy` continuously high with one IDLE cycle between conversions.
- Fairness: ch0 re-requests immediately after every `done` while ch1 is held high. Required: grants alternate 0,1,0,1.
- Req dropped mid-WAIT on ch1, with X/Y changed after grant. Required: `done[1]` still pulses; `angle_out` reflects the originally latched X/Y; `r2p_x`/`r2p_y` unchanged through WAIT.
- Reset asserted mid-WAIT. Required: all outputs 0 immediately (asynchronous); no `done` for the aborted request; after release, simultaneous ch1/ch3 requests grant ch1 first, since `ptr` resets to 0.
- Idle with `req`=0 for 50 cycles. Required: `busy`=0, `r2p_start`=0, `done`=0 throughout.
